// File: rtl/cw_pkg.sv
// cw_pkg: address map, FSM states and column record shared by the
// column-decoder host and the decoder itself.
package cw_pkg;

   localparam logic [3:0] ADDR_COLRST   = 4'd0;
   localparam logic [3:0] ADDR_COLDATA  = 4'd1;
   localparam logic [3:0] ADDR_BLACKOUT = 4'd3;

   typedef enum logic [3:0] {
      IDLE, POLL, FRST, LOAD, W0, W1, W2, W3, BLK
   } state_t;

   typedef struct packed {
      logic [15:0] top;
      logic [15:0] height;
      logic        dir;
      logic [2:0]  tex_type;
      logic [5:0]  tex_col;
      logic [15:0] sf;
   } column_rec_t;

   function automatic logic [15:0] pack_word0(input column_rec_t r);
      return {6'b0, r.dir, r.tex_type, r.tex_col};
   endfunction

endpackage

// File: rtl/avm_host_port.sv
// avm_host_port: registered Avalon-MM strobe/address/data with
// waitrequest hold and a same-cycle completion flag.
module avm_host_port (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_write,
   input  logic        cmd_read,
   input  logic [3:0]  cmd_address,
   input  logic [15:0] cmd_data,
   input  logic        waitrequest,
   output logic        done,
   output logic        write,
   output logic        read,
   output logic        chipselect,
   output logic [3:0]  address,
   output logic [15:0] writedata
);

   logic stall;

   assign stall      = (write | read) & waitrequest;
   assign done       = (write | read) & ~waitrequest;
   assign chipselect = write | read;

   // a stalled cycle freezes the whole command regardless of the FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write     <= 1'b0;
         read      <= 1'b0;
         address   <= '0;
         writedata <= '0;
      end else if (!stall) begin
         write     <= cmd_write;
         read      <= cmd_read;
         address   <= cmd_address;
         writedata <= cmd_data;
      end
   end

endmodule

// File: rtl/column_writer.sv
// column_writer: turns streamed column records into the decoder's
// per-frame reset write and four-word column bursts.
module column_writer
   import cw_pkg::*;
#(
   parameter int NUM_COLS    = 640,
   parameter bit VBLANK_SYNC = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        col_valid,
   output logic        col_ready,
   input  logic [15:0] col_top,
   input  logic [15:0] col_height,
   input  logic        col_dir,
   input  logic [2:0]  col_tex_type,
   input  logic [5:0]  col_tex_col,
   input  logic [15:0] col_sf,
   input  logic        blackout_req,
   output logic [3:0]  avm_address,
   output logic        avm_write,
   output logic        avm_read,
   output logic        avm_chipselect,
   output logic [15:0] avm_writedata,
   input  logic [15:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        frame_done,
   output logic        busy
);

   localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_COLS - 1);

   state_t      state, nxt;
   logic [CW-1:0] cnt;
   column_rec_t rec, in_rec;
   logic        blk_q, blk_diff, done;
   logic        cap, cnt_inc, cnt_clr, fd_set, blk_set;
   logic        cmd_write, cmd_read;
   logic [3:0]  cmd_address;
   logic [15:0] cmd_data;
   logic        unused_rd;

   assign unused_rd = ^avm_readdata[15:1];
   assign in_rec    = '{top: col_top, height: col_height, dir: col_dir,
                        tex_type: col_tex_type, tex_col: col_tex_col,
                        sf: col_sf};
   assign blk_diff  = blackout_req != blk_q;
   assign col_ready = state == LOAD;
   assign busy      = state != IDLE;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         rec        <= '0;
         blk_q      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= fd_set;
         if (cap)          rec <= in_rec;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CW'(1);
         if (blk_set)      blk_q <= avm_writedata[0];
      end
   end

   always_comb begin
      nxt         = state;
      cap         = 1'b0;
      cnt_inc     = 1'b0;
      cnt_clr     = 1'b0;
      fd_set      = 1'b0;
      blk_set     = 1'b0;
      cmd_write   = 1'b0;
      cmd_read    = 1'b0;
      cmd_address = '0;
      cmd_data    = '0;
      unique case (state)
         IDLE: if (cnt == '0) begin
            if (blk_diff)       nxt = BLK;
            else if (col_valid) nxt = VBLANK_SYNC ? POLL : FRST;
         end
         POLL: if (done && avm_readdata[0]) nxt = FRST;
         FRST: if (done) nxt = LOAD;
         LOAD: begin
            if (col_valid) begin
               cap = 1'b1;
               nxt = W0;
            end else if (blk_diff) begin
               nxt = BLK;
            end
         end
         W0: if (done) nxt = W1;
         W1: if (done) nxt = W2;
         W2: if (done) nxt = W3;
         W3: if (done) begin
            if (cnt == LAST) begin
               cnt_clr = 1'b1;
               fd_set  = 1'b1;
               nxt     = IDLE;
            end else begin
               cnt_inc = 1'b1;
               nxt     = LOAD;
            end
         end
         BLK: if (done) begin
            blk_set = 1'b1;
            nxt     = (cnt == '0) ? IDLE : LOAD;
         end
         default: nxt = IDLE;
      endcase
      // the port registers the command for the state being entered
      unique case (nxt)
         POLL: begin
            cmd_read    = 1'b1;
            cmd_address = ADDR_COLRST;
         end
         FRST: begin
            cmd_write   = 1'b1;
            cmd_address = ADDR_COLRST;
         end
         W0: begin
            cmd_write   = 1'b1;
            cmd_address = ADDR_COLDATA;
            cmd_data    = pack_word0(cap ? in_rec : rec);
         end
         W1: begin
            cmd_write   = 1'b1;
            cmd_address = ADDR_COLDATA;
            cmd_data    = rec.height;
         end
         W2: begin
            cmd_write   = 1'b1;
            cmd_address = ADDR_COLDATA;
            cmd_data    = rec.top;
         end
         W3: begin
            cmd_write   = 1'b1;
            cmd_address = ADDR_COLDATA;
            cmd_data    = rec.sf;
         end
         BLK: begin
            cmd_write   = 1'b1;
            cmd_address = ADDR_BLACKOUT;
            cmd_data    = {15'b0, blackout_req};
         end
         default: ;
      endcase
   end

   avm_host_port u_port (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_write   (cmd_write),
      .cmd_read    (cmd_read),
      .cmd_address (cmd_address),
      .cmd_data    (cmd_data),
      .waitrequest (avm_waitrequest),
      .done        (done),
      .write       (avm_write),
      .read        (avm_read),
      .chipselect  (avm_chipselect),
      .address     (avm_address),
      .writedata   (avm_writedata)
   );

endmodule

// File: tb/tb_column_writer.sv
// tb_column_writer: directed frames, polling, stalls, blackout and
// mid-frame reset against hand-computed bus traces.
module tb_column_writer;

   localparam int NC = 640;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        col_valid = 1'b0;
   logic        col_ready;
   logic [15:0] col_top = '0;
   logic [15:0] col_height = '0;
   logic        col_dir = 1'b0;
   logic [2:0]  col_tex_type = '0;
   logic [5:0]  col_tex_col = '0;
   logic [15:0] col_sf = '0;
   logic        blackout_req = 1'b0;
   logic [3:0]  avm_address;
   logic        avm_write, avm_read, avm_chipselect;
   logic [15:0] avm_writedata;
   logic [15:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;
   logic        frame_done, busy;

   logic        valid_b = 1'b0;
   logic        ready_b, write_b, read_b, cs_b, fd_b, busy_b;
   logic [3:0]  addr_b;
   logic [15:0] wdata_b, rdata_b;

   int n_chk = 0;
   int n_fail = 0;

   int cyc = 0, hs_cnt = 0, rd_a = 0, load_err = 0, cs_err = 0;
   int hold_err = 0, fd_cnt = 0, fd_cyc = 0, rd_b = 0;
   bit b_seen = 1'b0;
   logic [19:0] b_first = '0;
   bit pstall = 1'b0;
   logic [21:0] psnap = '0;
   logic [19:0] log_q[$];
   int st_q[$];

   int hs_base = 0;
   bit b_over = 1'b0, stall_hit = 1'b0, blk_hit = 1'b0;

   always #10 clk = ~clk;

   column_writer #(.NUM_COLS(NC), .VBLANK_SYNC(1'b0)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .col_valid(col_valid), .col_ready(col_ready),
      .col_top(col_top), .col_height(col_height), .col_dir(col_dir),
      .col_tex_type(col_tex_type), .col_tex_col(col_tex_col),
      .col_sf(col_sf), .blackout_req(blackout_req),
      .avm_address(avm_address), .avm_write(avm_write),
      .avm_read(avm_read), .avm_chipselect(avm_chipselect),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .frame_done(frame_done), .busy(busy)
   );

   column_writer #(.NUM_COLS(2), .VBLANK_SYNC(1'b1)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .col_valid(valid_b), .col_ready(ready_b),
      .col_top(col_top), .col_height(col_height), .col_dir(col_dir),
      .col_tex_type(col_tex_type), .col_tex_col(col_tex_col),
      .col_sf(col_sf), .blackout_req(1'b0),
      .avm_address(addr_b), .avm_write(write_b),
      .avm_read(read_b), .avm_chipselect(cs_b),
      .avm_writedata(wdata_b), .avm_readdata(rdata_b),
      .avm_waitrequest(1'b0),
      .frame_done(fd_b), .busy(busy_b)
   );

   // rd_b already counts the read in flight once past mid-cycle,
   // so reads 0..6 see status 0 and read 7 sees 1
   assign rdata_b = {15'b0, rd_b >= 8};

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (avm_write && !avm_waitrequest) begin
         log_q.push_back({avm_address, avm_writedata});
         st_q.push_back(cyc);
      end
      if (avm_read) rd_a <= rd_a + 1;
      if (col_valid && col_ready) hs_cnt <= hs_cnt + 1;
      if (col_ready && (avm_write || avm_read)) load_err <= load_err + 1;
      if (avm_chipselect != (avm_write | avm_read)) cs_err <= cs_err + 1;
      if (cs_b != (write_b | read_b)) cs_err <= cs_err + 1;
      if (frame_done) begin
         fd_cnt <= fd_cnt + 1;
         fd_cyc <= cyc;
      end
      if (pstall && {avm_write, avm_read, avm_address, avm_writedata} != psnap)
         hold_err <= hold_err + 1;
      pstall <= (avm_write | avm_read) & avm_waitrequest;
      psnap  <= {avm_write, avm_read, avm_address, avm_writedata};
      if (!b_seen) begin
         if (read_b) rd_b <= rd_b + 1;
         if (write_b) begin
            b_seen  <= 1'b1;
            b_first <= {addr_b, wdata_b};
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input int i, input int w);
      case (w)
         0:       return 16'h02C0 + 16'(i % 64);
         1:       return 16'd100;
         2:       return 16'(i);
         default: return 16'd512;
      endcase
   endfunction

   task automatic send_col(input int i, input int gap);
      int t;
      for (int g = 0; g < gap; g++) tick();
      col_valid    = 1'b1;
      col_top      = 16'(i);
      col_height   = 16'd100;
      col_dir      = 1'b1;
      col_tex_type = 3'd3;
      col_tex_col  = 6'(i % 64);
      col_sf       = 16'd512;
      t = 0;
      while (!col_ready && t < 200) begin
         tick();
         t++;
      end
      if (t >= 200) chk("ready_timeout", 32'(col_ready), 1);
      tick();
      col_valid = 1'b0;
   endtask

   task automatic wait_frame(input string tag, input int f0);
      int t;
      t = 0;
      while (fd_cnt == f0 && t < 5000) begin
         tick();
         t++;
      end
      chk({tag, "_fd_seen"}, 32'(fd_cnt != f0), 1);
      tick();
      tick();
      chk({tag, "_fd_pulse"}, fd_cnt - f0, 1);
      chk({tag, "_idle"}, 32'(busy), 0);
   endtask

   task automatic verify_frame(input string tag, input int blk_col);
      int bad, k, exp_n, n;
      bad   = 0;
      k     = 1;
      exp_n = 1 + 4 * NC + ((blk_col >= 0) ? 1 : 0);
      n     = log_q.size();
      chk({tag, "_len"}, n, exp_n);
      if (n == exp_n) begin
         chk({tag, "_frst"}, log_q[0], 20'h00000);
         for (int i = 0; i < NC; i++) begin
            for (int w = 0; w < 4; w++) begin
               if (log_q[k] != {4'd1, exp_word(i, w)}) bad++;
               k++;
            end
            if (i == blk_col) begin
               if (log_q[k] != {4'd3, 16'd1}) bad++;
               k++;
            end
         end
      end else begin
         bad = 1;
      end
      chk({tag, "_words"}, bad, 0);
      if (n >= 4) begin
         chk({tag, "_c639w0"}, log_q[n-4], 20'h102FF);
         chk({tag, "_c639w1"}, log_q[n-3], 20'h10064);
         chk({tag, "_c639w2"}, log_q[n-2], 20'h1027F);
         chk({tag, "_c639w3"}, log_q[n-1], 20'h10200);
      end
   endtask

   initial begin
      int f0, t, a1;

      repeat (3) tick();
      chk("rst_bus_a", {avm_write, avm_read, avm_chipselect,
                        avm_address, avm_writedata}, 0);
      chk("rst_ctl_a", {col_ready, frame_done, busy}, 0);
      chk("rst_b", {write_b, read_b, cs_b, addr_b, wdata_b,
                    ready_b, fd_b, busy_b}, 0);
      reset_n = 1'b1;
      tick();

      // vblank polling on the synchronised instance
      valid_b = 1'b1;
      t = 0;
      while (!b_seen && t < 100) begin
         tick();
         t++;
      end
      valid_b = 1'b0;
      chk("poll_done", 32'(b_seen), 1);
      chk("poll_reads", rd_b, 8);
      chk("poll_first_wr", b_first, 20'h00000);

      // frame A: back-to-back, no stalls
      log_q.delete();
      st_q.delete();
      f0 = fd_cnt;
      for (int i = 0; i < NC; i++) send_col(i, 0);
      wait_frame("A", f0);
      verify_frame("A", -1);
      chk("A_latency", (st_q.size() > 0) ? fd_cyc - st_q[0] : -1, 3201);

      // frame B: gaps, W1 stall on column 5, blackout at column 10
      log_q.delete();
      st_q.delete();
      f0      = fd_cnt;
      hs_base = hs_cnt;
      fork
         begin : stall_p
            logic [20:0] snap;
            while (!(hs_cnt - hs_base == 6 && avm_write &&
                     avm_address == 4'd1 && avm_writedata == 16'd100)
                   && !b_over) tick();
            if (!b_over) begin
               stall_hit = 1'b1;
               snap = {avm_write, avm_address, avm_writedata};
               avm_waitrequest = 1'b1;
               for (int k = 0; k < 3; k++) begin
                  tick();
                  chk("B_stall_hold",
                      {avm_write, avm_address, avm_writedata}, snap);
               end
               avm_waitrequest = 1'b0;
            end
         end
         begin : blk_p
            while (!(avm_write && avm_address == 4'd1 &&
                     avm_writedata == 16'd10) && !b_over) tick();
            if (!b_over) begin
               blk_hit      = 1'b1;
               blackout_req = 1'b1;
            end
         end
      join_none
      for (int i = 0; i < NC; i++)
         send_col(i, (i == 11) ? 6 : int'($urandom_range(0, 8)));
      wait_frame("B", f0);
      b_over = 1'b1;
      tick();
      chk("B_stall_seen", 32'(stall_hit), 1);
      chk("B_blk_seen", 32'(blk_hit), 1);
      verify_frame("B", 10);
      a1 = 0;
      foreach (log_q[k]) if (log_q[k][19:16] == 4'd1) a1++;
      chk("B_records", hs_cnt - hs_base, a1 / 4);
      chk("B_load_quiet", load_err, 0);
      chk("B_hold", hold_err, 0);

      // frame C: reset during column 300's W1
      log_q.delete();
      st_q.delete();
      for (int i = 0; i <= 300; i++) send_col(i, 0);
      tick();
      chk("C_w1", {avm_write, avm_address, avm_writedata},
          {1'b1, 4'd1, 16'd100});
      chk("C_busy", 32'(busy), 1);
      #3 reset_n = 1'b0;
      #1 chk("C_rst_async", {avm_write, avm_read, avm_chipselect,
                             avm_address, avm_writedata, col_ready,
                             frame_done, busy}, 0);
      blackout_req = 1'b0;
      tick();
      tick();
      log_q.delete();
      st_q.delete();
      reset_n = 1'b1;

      // frame D: fresh frame after reset
      f0 = fd_cnt;
      for (int i = 0; i < NC; i++) send_col(i, 0);
      wait_frame("D", f0);
      verify_frame("D", -1);
      chk("D_latency", (st_q.size() > 0) ? fd_cyc - st_q[0] : -1, 3201);
      chk("no_reads_a", rd_a, 0);
      chk("chipselect", cs_err, 0);
      chk("hold_all", hold_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/column_writer.md
# column_writer

Avalon-MM host that drives the column-decoder peripheral's register protocol from a streaming source of per-column ray-cast results. Each accepted column record becomes the four-word write burst at address 1. Each frame is opened with a column-index reset write at address 0, optionally gated on vertical blank by polling the peripheral's status word. It also forwards blackout-screen requests as an address-3 write. It sits between the ray-casting engine (or a bus-bridge FIFO) and the decoder's Avalon slave port.

## Interface
- NUM_COLS, 640: columns per frame.
- VBLANK_SYNC, 1: when 1, each frame waits for status readdata[0]==1 before the address-0 write.
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- col_valid  in  1  column record valid.
- col_ready  out  1  record accepted when col_valid && col_ready.
- col_top  in  16  signed wall top row.
- col_height  in  16  wall height in rows.
- col_dir  in  1  wall face (1 = full brightness).
- col_tex_type  in  3  texture select.
- col_tex_col  in  6  texture column.
- col_sf  in  16  texture row scale factor.
- blackout_req  in  1  level; the desired blackout state.
- avm_address  out  4  host address.
- avm_write  out  1  write strobe.
- avm_read  out  1  read strobe.
- avm_chipselect  out  1  equals avm_write | avm_read.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  read data, valid in the same cycle as the read when avm_waitrequest==0.
- avm_waitrequest  in  1  stall; tie to 0 for the decoder.
- frame_done  out  1  one-cycle pulse after the last column's fourth write completes.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, POLL, FRST, LOAD, W0, W1, W2, W3, BLK.
- IDLE: transitions occur only when the column counter is 0.
  - Priority 1: blackout_req != blk_q goes to BLK.
  - Priority 2: col_valid goes to POLL if VBLANK_SYNC, otherwise to FRST.
- POLL: avm_read=1, address 0.
  - Completes when avm_waitrequest==0.
  - readdata[0]==1 goes to FRST; otherwise re-reads the next cycle.
- FRST: write address 0, data 0, then go to LOAD.
- LOAD: col_ready=1.
  - On handshake, capture the record and go to W0.
  - If blackout_req != blk_q and no record is offered, go to BLK first. Blackout is serviced only between columns, never inside a burst.
- Write words, all at address 1:
  - W0: {6'b0, dir, tex_type, tex_col}.
  - W1: col_height.
  - W2: col_top.
  - W3: col_sf.
- After W3:
  - Increment the column counter.
  - If the counter was NUM_COLS-1: clear it, pulse frame_done, go to IDLE.
  - Otherwise go to LOAD.
- BLK: write address 3, data {15'b0, blackout_req}; blk_q <= blackout_req.
  - Return to IDLE if the counter is 0, otherwise to LOAD.
- Every bus cycle holds address, data and strobe stable while avm_waitrequest==1. The state advances only on the cycle where the strobe is high and waitrequest is low.
- Column counter: log2(NUM_COLS) bits. It never exceeds NUM_COLS-1 and wraps to 0 only via the frame-end path.
- Reset (async, any state): return to IDLE.
  - All outputs 0, counter 0, blk_q 0.
  - A partially sent column is discarded. The next frame's address-0 write resynchronises the decoder's write stage.

## Timing
- Reset values: avm_* outputs 0, col_ready 0, frame_done 0, busy 0.
- All outputs are registered or decoded directly from the state register. col_ready has no combinational path from col_valid.
- With no stalls:
  - Column: 5 cycles (LOAD + W0..W3). Back-to-back columns sustain 1 record per 5 cycles.
  - Frame: 1 + 5*NUM_COLS cycles after vblank is seen (3201 for 640 columns). This fits in one 800,000-cycle frame.
- frame_done is asserted in the cycle after the final W3 completes.
- If col_valid drops mid-frame, the block waits in LOAD with no bus activity.

## Structure
- Shared package cw_pkg holds:
  - the address constants (ADDR_COLRST=0, ADDR_COLDATA=1, ADDR_BLACKOUT=3);
  - the state enum;
  - a packed column_rec_t struct (top, height, dir, tex_type, tex_col, sf).
- Decoder-side code uses the same address constants.
- One sub-module: avm_host_port. It holds the strobe, address and data registers and generates the "done" handshake under waitrequest. The FSM stays in column_writer.

## Test plan
- VBLANK_SYNC=0, waitrequest=0, 640 records with top=i, height=100, dir=1, tex=3, texcol=i%64, sf=512.
  - Required: write 0@addr0, then 2560 addr-1 writes in the order {word0, 100, i, 512}.
  - frame_done at cycle 3201.
- VBLANK_SYNC=1, readdata[0]=0 for 7 polls then 1.
  - Required: exactly 8 reads, then the address-0 write.
- waitrequest high for 3 cycles during W1.
  - Required: address, data and write held for 4 cycles; no word skipped or duplicated.
- blackout_req rises during column 10's W2.
  - Required: the address-3 write with data 1 appears after column 10's W3 and before column 11's W0.
- reset_n low during column 300's W1, then a new frame.
  - Required: outputs are 0 asynchronously; the next activity is an address-0 write and the counter restarts at 0.
- col_valid gaps of random length.
  - Required: no bus strobes while in LOAD; the record count equals the addr-1 write count divided by 4.
